envelope_apply: RTL

//  Vocoder synthesis stage: applies per-band envelopes to per-band carrier samples and mixes the bands.
//  - Per band: clamps the envelope to >= 0, then multiplies the carrier by it in Q(ENV_FRAC).
//  - Sums the BANDS products and emits one output sample per frame.
//  - Sits after the carrier filter bank and the envelope followers; its output feeds the DAC path.

---
 rtl/envelope_apply.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/envelope_apply.sv
// -----------------------------------------------------------------------------
// envelope_apply
//   Vocoder synthesis stage. Each accepted beat carries one band of a frame:
//   the envelope is clamped to >= 0, multiplied with the carrier in
//   Q(ENV_FRAC), and the BANDS products of a frame are summed into one output
//   sample.
//
//   Pipeline: S1 operand register -> S2 product register -> S3 accumulator and
//   output register. The last band accepted in cycle T shows up on
//   sample_out/valid_out in cycle T+3.
//
// Ports
//   clk_in        system clock
//   rst_in        synchronous reset, active-high
//   valid_in      band operands valid (always accepted)
//   first_in      this beat is band 0 of a frame (qualified by valid_in)
//   carrier_in    signed carrier band sample, WIDTH bits
//   envelope_in   signed envelope, Q.ENV_FRAC, WIDTH bits
//   sample_out    signed mixed output, held between frames
//   valid_out     1-cycle pulse when sample_out updates
//   sync_err_out  1-cycle pulse, same cycle as a beat whose first_in arrived
//                 mid-frame (partial frame is abandoned)
//
// Configuration
//   ENVELOPE_APPLY_SAT_EN  defined: narrowing to WIDTH saturates
//                          undefined: narrowing keeps the low WIDTH bits
// -----------------------------------------------------------------------------
module envelope_apply #(
  parameter int WIDTH    = 24,
  parameter int BANDS    = 16,
  parameter int ENV_FRAC = 20
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  input  logic             first_in,
  input  logic [WIDTH-1:0] carrier_in,
  input  logic [WIDTH-1:0] envelope_in,
  output logic [WIDTH-1:0] sample_out,
  output logic             valid_out,
  output logic             sync_err_out
);

  localparam int CW     = $clog2(BANDS);
  localparam int PW     = 2 * WIDTH;
  localparam int AW     = PW + CW;
  localparam int STAGES = 2;

  // ---------------------------------------------------------------------------
  // Band counter. A first_in beat is band 0 whatever the counter says; the
  // counter resets to 0 so the first beat after reset is band 0 as well.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] band;

  always_comb begin
    band = cnt_q;
    if (valid_in && first_in) band = '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else if (valid_in) begin
      cnt_q <= (band == CW'(BANDS - 1)) ? '0 : band + 1'b1;
    end
  end

  // A mid-frame first_in restarts at band 0. The abandoned partial frame never
  // reaches its last band, and the restart beat reloads the accumulator, so
  // nothing more is needed to discard it.
  assign sync_err_out = !rst_in && valid_in && first_in && (cnt_q != '0);

  // ---------------------------------------------------------------------------
  // Valid shift register: vld_pipe[0] = S1 holds a beat, vld_pipe[1] = S2.
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] vld_pipe;

  always_ff @(posedge clk_in) begin
    if (rst_in) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-2:0], valid_in};
  end

  // ---------------------------------------------------------------------------
  // S1: operands and band index; negative envelopes clamp to 0.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] s1_car;
  logic [WIDTH-1:0] s1_env;
  logic [CW-1:0]    s1_band;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_car  <= '0;
      s1_env  <= '0;
      s1_band <= '0;
    end else if (valid_in) begin
      s1_car  <= carrier_in;
      s1_env  <= envelope_in[WIDTH-1] ? '0 : envelope_in;
      s1_band <= band;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: full-width signed product. The clamped envelope is non-negative, so
  // it zero-extends; the carrier sign-extends. The low PW bits of the PW x PW
  // product are the exact signed product.
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] car_x;
  logic signed [PW-1:0] env_x;
  logic signed [PW-1:0] s2_prod;
  logic                 s2_first;
  logic                 s2_last;

  assign car_x = {{WIDTH{s1_car[WIDTH-1]}}, s1_car};
  assign env_x = {{WIDTH{1'b0}}, s1_env};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s2_prod  <= '0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
    end else if (vld_pipe[0]) begin
      s2_prod  <= car_x * env_x;
      s2_first <= (s1_band == '0);
      s2_last  <= (s1_band == CW'(BANDS - 1));
    end
  end

  // ---------------------------------------------------------------------------
  // S3: accumulate. Band 0 loads, so a following frame's band 0 never mixes
  // with the sum that just completed; the output is taken from acc_next in the
  // same cycle the last band lands.
  // ---------------------------------------------------------------------------
  logic signed [AW-1:0]    acc_q;
  logic signed [AW-1:0]    prod_x;
  logic signed [AW-1:0]    acc_next;
  logic        [WIDTH-1:0] narrow;

  assign prod_x   = {{CW{s2_prod[PW-1]}}, s2_prod};
  assign acc_next = s2_first ? prod_x : acc_q + prod_x;

`ifdef ENVELOPE_APPLY_SAT_EN
  localparam logic signed [AW-1:0] SMAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [AW-1:0] shifted;
  assign shifted = acc_next >>> ENV_FRAC;

  always_comb begin
    narrow = shifted[WIDTH-1:0];
    if (shifted > SMAX)      narrow = {1'b0, {(WIDTH-1){1'b1}}};
    else if (shifted < SMIN) narrow = {1'b1, {(WIDTH-1){1'b0}}};
  end
`else
  // Low WIDTH bits of the arithmetic shift are just a slice of the sum.
  assign narrow = acc_next[ENV_FRAC +: WIDTH];
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc_q      <= '0;
      sample_out <= '0;
      valid_out  <= 1'b0;
    end else begin
      valid_out <= vld_pipe[1] && s2_last;
      if (vld_pipe[1]) acc_q <= acc_next;
      if (vld_pipe[1] && s2_last) sample_out <= narrow;
    end
  end

endmodule
